// File: rtl/mem_port_arbiter.sv
// Arbitrates N requesters onto one memory-controller port, one transaction in flight.
// Requester 0 has fixed priority, bounded by a starvation counter; requesters 1..N-1 rotate.
module mem_port_arbiter #(
    parameter int unsigned N            = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned IDW          = $clog2(N)
) (
    input  logic              clk,
    input  logic              res,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      req_we,
    input  logic [N*32-1:0]   req_addr,
    input  logic [N*32-1:0]   req_wdata,
    input  logic [N*4-1:0]    req_wstrb,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [31:0]       m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_resp_valid,
    input  logic [31:0]       m_resp_rdata,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } payload_t;

    state_e           state_q, state_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    payload_t         pay_q, pay_d;
    logic             m_valid_q, m_valid_d;
    logic [N-1:0]     req_ready_q, req_ready_d;
    logic [N-1:0]     resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             busy_q, busy_d;

    logic             others_valid;
    logic             take_prio;
    logic             rr_found;
    logic [IDW-1:0]   rr_sel;
    logic [IDW-1:0]   gnt_sel;
    payload_t         pay_sel;

    // Grant selection: priority requester 0 unless starving others, else round-robin from rr_q+1.
    always_comb begin
        int unsigned idx;
        others_valid = |req_valid[N-1:1];
        take_prio    = req_valid[0] && ((starve_q < LIMIT_C) || !others_valid);
        rr_found     = 1'b0;
        rr_sel       = '0;
        idx          = 0;
        for (int unsigned k = 1; k < N; k++) begin
            idx = ((32'(rr_q) + k - 1) % (N - 1)) + 1;
            if (!rr_found && req_valid[IDW'(idx)]) begin
                rr_found = 1'b1;
                rr_sel   = IDW'(idx);
            end
        end
        gnt_sel = take_prio ? '0 : rr_sel;
        pay_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_sel == IDW'(i)) begin
                pay_sel = {req_we[i], req_addr[32*i +: 32], req_wdata[32*i +: 32], req_wstrb[4*i +: 4]};
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        pay_d        = pay_q;
        m_valid_d    = m_valid_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        busy_d       = busy_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d     = SEND;
                    gnt_d       = gnt_sel;
                    pay_d       = pay_sel;
                    m_valid_d   = 1'b1;
                    req_ready_d = N'(1) << gnt_sel;
                    busy_d      = 1'b1;
                    if (take_prio) begin
                        if (others_valid && (starve_q < LIMIT_C)) begin
                            starve_d = starve_q + CW'(1);
                        end
                    end else begin
                        starve_d = '0;
                        rr_d     = rr_sel;
                    end
                end
            end
            SEND: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_resp_valid) begin
                    resp_rdata_d = m_resp_rdata;
                    resp_valid_d = N'(1) << gnt_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            rr_q         <= IDW'(N - 1);
            gnt_q        <= '0;
            pay_q        <= '0;
            m_valid_q    <= 1'b0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            pay_q        <= pay_d;
            m_valid_q    <= m_valid_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign m_valid    = m_valid_q;
    assign m_we       = pay_q.we;
    assign m_addr     = pay_q.addr;
    assign m_wdata    = pay_q.wdata;
    assign m_wstrb    = pay_q.wstrb;
    assign grant_id   = gnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter (N=3, STARVE_LIMIT=4) against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned N   = 3;
    localparam int unsigned SL  = 4;
    localparam int unsigned IDW = $clog2(N);

    logic              clk;
    logic              res;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_wstrb;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_rdata;
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_resp_valid;
    logic [31:0]       m_resp_rdata;
    logic [IDW-1:0]    grant_id;
    logic              busy;

    mem_port_arbiter #(.N(N), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester payloads as the requesters see them.
    logic        p_we    [N];
    logic [31:0] p_addr  [N];
    logic [31:0] p_wdata [N];
    logic [3:0]  p_wstrb [N];

    // Model state: consecutive contested priority grants and last round-robin winner.
    int m_starve;
    int m_rr;

    int exp_starve_seq [15] = '{0,0,0,0,1,0,0,0,0,2,0,0,0,0,1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
        int others;
        int c;
        others = 0;
        for (int i = 1; i < int'(N); i++) if (mask[i]) others++;
        if (mask[0] && (m_starve < int'(SL) || others == 0)) return 0;
        for (int k = 1; k < int'(N); k++) begin
            c = ((m_rr - 1 + k) % (int'(N) - 1)) + 1;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_commit(input int g, input logic [N-1:0] mask);
        if (g == 0) begin
            if ((mask >> 1) != 0 && m_starve < int'(SL)) m_starve++;
        end else begin
            m_starve = 0;
            m_rr     = g;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < int'(N); i++) begin
            req_we[i]           = p_we[i];
            req_addr[32*i +: 32] = p_addr[i];
            req_wdata[32*i +: 32] = p_wdata[i];
            req_wstrb[4*i +: 4]  = p_wstrb[i];
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < int'(N); i++) begin
            p_we[i]    = 1'($urandom_range(0, 1));
            p_addr[i]  = $urandom;
            p_wdata[i] = $urandom;
            p_wstrb[i] = 4'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_valid"},    64'(m_valid), 64'd0);
        chk({tag, "_m_we"},       64'(m_we), 64'd0);
        chk({tag, "_m_addr"},     64'(m_addr), 64'd0);
        chk({tag, "_m_wdata"},    64'(m_wdata), 64'd0);
        chk({tag, "_m_wstrb"},    64'(m_wstrb), 64'd0);
        chk({tag, "_req_ready"},  64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
        chk({tag, "_grant_id"},   64'(grant_id), 64'd0);
        chk({tag, "_busy"},       64'(busy), 64'd0);
    endtask

    task automatic do_reset(input bit check_outs);
        req_valid    = '0;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        res          = 1'b1;
        tick();
        if (check_outs) check_all_zero("rst");
        tick();
        res      = 1'b0;
        m_starve = 0;
        m_rr     = int'(N) - 1;
    endtask

    // One full transaction starting in IDLE; may inject spurious responses during backpressure.
    task automatic run_txn(input logic [N-1:0] mask, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdata);
        int          eg;
        logic [N-1:0] oh;
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        eg      = model_pick(mask);
        e_we    = p_we[eg];
        e_addr  = p_addr[eg];
        e_wdata = p_wdata[eg];
        e_wstrb = p_wstrb[eg];
        oh      = '0;
        oh[eg]  = 1'b1;
        pack();
        req_valid = mask;
        tick();
        chk("acc_req_ready", 64'(req_ready), 64'(oh));
        chk("acc_grant_id",  64'(grant_id), 64'(eg));
        chk("acc_m_valid",   64'(m_valid), 64'd1);
        chk("acc_busy",      64'(busy), 64'd1);
        chk("acc_m_payload", {m_we, m_wstrb, m_addr}, {e_we, e_wstrb, e_addr});
        chk("acc_m_wdata",   64'(m_wdata), 64'(e_wdata));
        req_valid[eg] = 1'b0;
        p_addr[eg]    = ~p_addr[eg];
        p_wdata[eg]   = p_wdata[eg] ^ 32'h5A5A_0F0F;
        p_we[eg]      = ~p_we[eg];
        pack();
        for (int i = 0; i < rdy_dly; i++) begin
            m_resp_valid = 1'($urandom_range(0, 1));
            m_resp_rdata = $urandom;
            tick();
            m_resp_valid = 1'b0;
            chk("bp_m_valid",    64'(m_valid), 64'd1);
            chk("bp_req_ready",  64'(req_ready), 64'd0);
            chk("bp_resp_valid", 64'(resp_valid), 64'd0);
            chk("bp_payload",    {m_we, m_wstrb, m_addr}, {e_we, e_wstrb, e_addr});
            chk("bp_wdata",      64'(m_wdata), 64'(e_wdata));
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("wait_m_valid", 64'(m_valid), 64'd0);
        chk("wait_busy",    64'(busy), 64'd1);
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            chk("wait_resp_valid", 64'(resp_valid), 64'd0);
            chk("wait_busy_hold",  64'(busy), 64'd1);
        end
        m_resp_valid = 1'b1;
        m_resp_rdata = rdata;
        tick();
        m_resp_valid = 1'b0;
        chk("resp_valid", 64'(resp_valid), 64'(oh));
        chk("resp_rdata", 64'(resp_rdata), 64'(rdata));
        chk("resp_busy",  64'(busy), 64'd0);
        model_commit(eg, mask);
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask;
        res          = 1'b1;
        req_valid    = '0;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        rand_payload();
        pack();
        do_reset(1'b1);

        // Single write from requester 1.
        rand_payload();
        p_we[1] = 1'b1; p_addr[1] = 32'h100; p_wdata[1] = 32'hDEADBEEF; p_wstrb[1] = 4'hF;
        run_txn(3'b010, 0, 1, $urandom);

        // Read from requester 0 with five cycles of backpressure.
        rand_payload();
        p_we[0] = 1'b0;
        run_txn(3'b001, 5, 0, 32'h12345678);

        // Starvation: everyone always requesting.
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            rand_payload();
            run_txn(3'b111, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            chk("starve_order", 64'(grant_id), 64'(exp_starve_seq[i]));
        end

        // Round-robin wrap over requesters 1 and 2.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            run_txn(3'b110, 0, 0, $urandom);
            chk("rr_order", 64'(grant_id), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Reset while waiting for the downstream response.
        rand_payload();
        pack();
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        res = 1'b1;
        tick();
        res = 1'b0;
        m_starve = 0;
        m_rr     = int'(N) - 1;
        check_all_zero("midrst");
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hCAFE_F00D;
        tick();
        m_resp_valid = 1'b0;
        chk("late_resp_valid", 64'(resp_valid), 64'd0);
        chk("late_busy",       64'(busy), 64'd0);
        chk("late_resp_rdata", 64'(resp_rdata), 64'd0);
        rand_payload();
        run_txn(3'b110, 0, 0, $urandom);
        chk("post_rst_grant", 64'(grant_id), 64'd1);

        // Spurious response while idle.
        m_resp_valid = 1'b1;
        m_resp_rdata = $urandom;
        tick();
        m_resp_valid = 1'b0;
        chk("idle_spur_resp_valid", 64'(resp_valid), 64'd0);
        chk("idle_spur_busy",       64'(busy), 64'd0);
        tick();
        chk("idle_spur_m_valid",    64'(m_valid), 64'd0);

        // Spurious responses while in SEND come from the backpressure cycles here.
        do_reset(1'b0);
        for (int i = 0; i < 60; i++) begin
            rand_payload();
            mask = N'($urandom_range(1, (1 << N) - 1));
            run_txn(mask, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
